uart_msg_sequencer: RTL and testbench

UART_MSG_SEQUENCER -- requirements
Module: uart_msg_sequencer

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_send.sv | 54 +++++
 rtl/uart_msg_sequencer.sv | 128 ++++++++++++
 tb/tb_uart_msg_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART frame constant, sequencer state encoding and sizing helper
package uart_pkg;

  // 8N1 frame: start + 8 data + stop
  localparam int FRAME_BITS = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_WAIT_CHAR,
    ST_GAP
  } seq_state_t;

  // Counter width for a terminal value; never zero so single-value counters still exist
  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/uart_send.sv
// rtl/uart_send.sv - 8N1 serializer, one frame per valid pulse, idle high
module uart_send
  import uart_pkg::*;
#(
  parameter int CPB = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       dout
);

  localparam int BAUD_W = clog2_min1(CPB);
  localparam int BIT_W  = clog2_min1(FRAME_BITS);

  // LSB is the bit on the line; ones shift in so the line rests high after the stop bit
  logic [FRAME_BITS-1:0] shreg;
  logic [BAUD_W-1:0]     baud_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic                  active;

  // Frame shifter: a new valid always restarts the frame, which lets the caller
  // issue the next character on the final cycle of the previous stop bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg    <= '1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      active   <= 1'b0;
    end else if (valid) begin
      shreg    <= {1'b1, data, 1'b0};
      baud_cnt <= '0;
      bit_cnt  <= '0;
      active   <= 1'b1;
    end else if (active) begin
      if (baud_cnt == BAUD_W'(CPB - 1)) begin
        baud_cnt <= '0;
        shreg    <= {1'b1, shreg[FRAME_BITS-1:1]};
        if (bit_cnt == BIT_W'(FRAME_BITS - 1)) begin
          bit_cnt <= '0;
          active  <= 1'b0;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
    end
  end

  assign dout = shreg[0];

endmodule

// File: rtl/uart_msg_sequencer.sv
// rtl/uart_msg_sequencer.sv - sends a latched message over UART, one-shot or repeating with a gap
module uart_msg_sequencer
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int MAX_LEN    = 16,
  parameter int GAP_CYCLES = 20_000_000
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  // repeat mode: 1 = loop after the gap, 0 = one-shot
  input  logic                                repeat_en,
  input  logic                                stop,
  input  logic [8*MAX_LEN-1:0]                msg,
  input  logic [$clog2(MAX_LEN+1)-1:0]        msg_len,
  output logic                                uart_tx,
  output logic                                busy,
  output logic                                done,
  output logic [clog2_min1(MAX_LEN)-1:0]      char_idx
);

  localparam int CPB     = CLK_HZ / BAUD;
  localparam int SLOT    = FRAME_BITS * CPB;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);
  localparam int CNT_MAX = (SLOT > GAP_CYCLES) ? SLOT : GAP_CYCLES;
  localparam int CNT_W   = clog2_min1(CNT_MAX);

  seq_state_t           state, state_next;
  logic [8*MAX_LEN-1:0] msg_q;
  logic [LEN_W-1:0]     len_q;
  logic [LEN_W-1:0]     len_in;
  logic                 rep_q;
  logic                 stop_pend;
  logic [CNT_W-1:0]     cnt;
  logic                 slot_done;
  logic                 gap_done;
  logic                 more_chars;
  logic                 send_valid;
  logic [7:0]           send_data;

  // SEND occupies one cycle of the slot, so WAIT_CHAR ends one cycle early
  assign slot_done  = (cnt == CNT_W'(SLOT - 2));
  assign gap_done   = (cnt == CNT_W'(GAP_CYCLES - 1));
  assign len_in     = (msg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : msg_len;
  assign more_chars = (LEN_W'(char_idx) + LEN_W'(1)) < len_q;
  assign send_valid = (state == ST_SEND);
  assign send_data  = msg_q[8*char_idx +: 8];
  assign busy       = (state != ST_IDLE);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:      if (start) state_next = ST_LOAD;
      ST_LOAD:      state_next = (len_in == '0) ? ST_IDLE : ST_SEND;
      ST_SEND:      state_next = ST_WAIT_CHAR;
      ST_WAIT_CHAR: begin
        if (slot_done) begin
          if (stop_pend)       state_next = ST_IDLE;
          else if (more_chars) state_next = ST_SEND;
          else if (rep_q)      state_next = ST_GAP;
          else                 state_next = ST_IDLE;
        end
      end
      ST_GAP:       if (gap_done) state_next = stop_pend ? ST_IDLE : ST_LOAD;
      default:      state_next = ST_IDLE;
    endcase
  end

  // Shared slot/gap counter, restarts whenever its state is entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if ((state == ST_WAIT_CHAR && !slot_done) || (state == ST_GAP && !gap_done)) begin
      cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end

  // Message latch and character index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      msg_q    <= '0;
      len_q    <= '0;
      rep_q    <= 1'b0;
      char_idx <= '0;
    end else if (state == ST_LOAD) begin
      msg_q    <= msg;
      len_q    <= len_in;
      rep_q    <= repeat_en;
      char_idx <= '0;
    end else if (state == ST_WAIT_CHAR && state_next == ST_SEND) begin
      char_idx <= char_idx + 1'b1;
    end
  end

  // Stop request held until the sequencer is back in IDLE; done marks the return
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stop_pend <= 1'b0;
      done      <= 1'b0;
    end else begin
      if (state == ST_IDLE) stop_pend <= 1'b0;
      else if (stop)        stop_pend <= 1'b1;
      done <= (state != ST_IDLE) && (state_next == ST_IDLE);
    end
  end

  uart_send #(
    .CPB (CPB)
  ) u_send (
    .clk   (clk),
    .rst   (rst),
    .data  (send_data),
    .valid (send_valid),
    .dout  (uart_tx)
  );

endmodule

// File: tb/tb_uart_msg_sequencer.sv
// tb/tb_uart_msg_sequencer.sv - self-checking bench for uart_msg_sequencer
module tb_uart_msg_sequencer;

  localparam int CLK_HZ  = 1000;
  localparam int BAUD    = 100;
  localparam int MAX_LEN = 4;
  localparam int GAP     = 50;
  localparam int SLOT    = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        repeat_en = 1'b0;
  logic        stop = 1'b0;
  logic [31:0] msg = '0;
  logic [2:0]  msg_len = '0;
  logic        uart_tx;
  logic        busy;
  logic        done;
  logic [1:0]  char_idx;

  uart_msg_sequencer #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .MAX_LEN    (MAX_LEN),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .repeat_en (repeat_en),
    .stop      (stop),
    .msg       (msg),
    .msg_len   (msg_len),
    .uart_tx   (uart_tx),
    .busy      (busy),
    .done      (done),
    .char_idx  (char_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp = 0;
  int n_bad = 0;

  int rx_bytes[$];
  int rx_times[$];
  int done_times[$];
  int rx_bad_stop = 0;
  int rx_start = 0;
  bit rx_on = 1'b0;
  logic [7:0] rx_byte;

  // Line decoder sampling mid-bit (CPB=10) plus done-pulse recorder
  always @(negedge clk) begin
    int off;
    if (rst) begin
      rx_on = 1'b0;
    end else if (!rx_on) begin
      if (uart_tx === 1'b0) begin
        rx_on = 1'b1;
        rx_start = cyc;
      end
    end else begin
      off = cyc - rx_start;
      if (off >= 15 && off <= 85 && (off % 10) == 5) rx_byte[(off - 15) / 10] = uart_tx;
      if (off == 95) begin
        if (uart_tx !== 1'b1) rx_bad_stop++;
        rx_bytes.push_back(int'(rx_byte));
        rx_times.push_back(rx_start);
        rx_on = 1'b0;
      end
    end
    if (done === 1'b1) done_times.push_back(cyc);
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: characters sent are the first min(len, MAX_LEN) bytes;
  // one slot per character plus the LOAD and SEND lead-in cycles
  function automatic int model_len(input int len);
    return (len > MAX_LEN) ? MAX_LEN : len;
  endfunction

  function automatic int model_byte(input logic [31:0] m, input int k);
    return int'(m[8*k +: 8]);
  endfunction

  function automatic int model_latency(input int len);
    return 2 + SLOT * model_len(len);
  endfunction

  task automatic clear_obs();
    rx_bytes.delete();
    rx_times.delete();
    done_times.delete();
    rx_bad_stop = 0;
  endtask

  task automatic pulse_start(output int t0);
    @(negedge clk);
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_done(input int t0, input int bound);
    while (done_times.size() == 0 && (cyc - t0) < bound) @(negedge clk);
    repeat (20) @(negedge clk);
  endtask

  task automatic run_oneshot(input string tag, input logic [31:0] m, input int len,
                             input int exp_n, input int exp_lat);
    int t0;
    clear_obs();
    @(negedge clk);
    msg = m;
    msg_len = 3'(len);
    repeat_en = 1'b0;
    pulse_start(t0);
    wait_done(t0, 1000);
    check({tag, " done latency"}, (done_times.size() > 0) ? done_times[0] - t0 : -1, exp_lat);
    check({tag, " done count"}, done_times.size(), 1);
    check({tag, " frames"}, rx_bytes.size(), exp_n);
    check({tag, " stop bits"}, rx_bad_stop, 0);
    for (int k = 0; k < rx_bytes.size() && k < exp_n; k++)
      check($sformatf("%s byte%0d", tag, k), rx_bytes[k], model_byte(m, k));
    if (rx_times.size() > 0) check({tag, " first start bit"}, rx_times[0] - t0, 3);
    for (int k = 1; k < rx_times.size(); k++)
      check($sformatf("%s spacing%0d", tag, k), rx_times[k] - rx_times[k-1], SLOT);
    check({tag, " busy after"}, int'(busy), 0);
    check({tag, " line idle"}, int'(uart_tx), 1);
  endtask

  typedef struct {
    logic [31:0] m;
    int          len;
    int          exp_n;
    int          exp_lat;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int t0;
    int exp4[4];
    logic [31:0] rm;
    int rl;

    tbl[0] = '{32'h44434241, 4, 4, 402};
    tbl[1] = '{32'h5A595857, 2, 2, 202};
    tbl[2] = '{32'h41414141, 0, 0, 2};
    tbl[3] = '{32'h000000A5, 1, 1, 102};
    tbl[4] = '{32'h04030201, 7, 4, 402};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset uart_tx", int'(uart_tx), 1);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset char_idx", int'(char_idx), 0);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("idle after reset busy", int'(busy), 0);
    check("idle after reset frames", rx_bytes.size(), 0);

    // Table-driven one-shot messages
    for (int i = 0; i < 5; i++)
      run_oneshot($sformatf("vec%0d", i), tbl[i].m, tbl[i].len, tbl[i].exp_n, tbl[i].exp_lat);

    // Randomized one-shot messages against the model
    for (int i = 0; i < 6; i++) begin
      rm = $urandom;
      rl = int'($urandom_range(0, 7));
      run_oneshot($sformatf("rand%0d", i), rm, rl, model_len(rl), model_latency(rl));
    end

    // Repeat mode: "AB", gap, then the message changed mid-flight appears as "CD"
    clear_obs();
    @(negedge clk);
    msg = 32'h00004241;
    msg_len = 3'd2;
    repeat_en = 1'b1;
    pulse_start(t0);
    wait_until(t0 + 50);
    msg = 32'h00004443;
    repeat_en = 1'b0;
    wait_until(t0 + 150);
    check("rep busy mid", int'(busy), 1);
    check("rep char_idx mid", int'(char_idx), 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(t0, 2000);
    exp4 = '{65, 66, 67, 68};
    check("rep frames", rx_bytes.size(), 4);
    for (int k = 0; k < rx_bytes.size() && k < 4; k++)
      check($sformatf("rep byte%0d", k), rx_bytes[k], exp4[k]);
    if (rx_times.size() == 4) begin
      check("rep spacing0", rx_times[1] - rx_times[0], SLOT);
      check("rep gap spacing", rx_times[2] - rx_times[1], SLOT + GAP + 1);
      check("rep spacing2", rx_times[3] - rx_times[2], SLOT);
    end
    check("rep done latency", (done_times.size() > 0) ? done_times[0] - t0 : -1,
          2 + 2 * SLOT + GAP + 1 + 2 * SLOT);
    check("rep done count", done_times.size(), 1);

    // Stop during char 1: char 1 completes, char 2 never sent
    clear_obs();
    @(negedge clk);
    msg = 32'h44434241;
    msg_len = 3'd4;
    repeat_en = 1'b0;
    pulse_start(t0);
    wait_until(t0 + 150);
    check("stop char_idx", int'(char_idx), 1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_done(t0, 1000);
    check("stop frames", rx_bytes.size(), 2);
    check("stop stop bits", rx_bad_stop, 0);
    for (int k = 0; k < rx_bytes.size() && k < 2; k++)
      check($sformatf("stop byte%0d", k), rx_bytes[k], model_byte(32'h44434241, k));
    check("stop done latency", (done_times.size() > 0) ? done_times[0] - t0 : -1, 2 + 2 * SLOT);
    check("stop busy after", int'(busy), 0);

    // Reset mid-frame: line, busy and index return immediately, then stay idle
    clear_obs();
    pulse_start(t0);
    wait_until(t0 + 135);
    check("pre-reset line low", int'(uart_tx), 0);
    rst = 1'b1;
    #1;
    check("rst uart_tx", int'(uart_tx), 1);
    check("rst busy", int'(busy), 0);
    check("rst char_idx", int'(char_idx), 0);
    check("rst done", int'(done), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    clear_obs();
    repeat (300) @(negedge clk);
    check("post-rst frames", rx_bytes.size(), 0);
    check("post-rst done", done_times.size(), 0);
    check("post-rst busy", int'(busy), 0);
    check("post-rst line", int'(uart_tx), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
